// File: rtl/f1_start_ctrl.sv
// f1_start_ctrl: start-sequence controller that drives the en input of the
// F1 light FSM. It lights the gantry with eight evenly spaced en pulses,
// holds all lights on for a pseudo-random delay, fires a ninth en to put the
// lights out and then measures the driver's reaction time in ticks.
//
// Build option:
//   F1_START_FIXED_DELAY_EN  when defined, the all-on hold is exactly
//                            DELAY_MIN ticks and the LFSR is not built.
//                            When undefined, the hold is DELAY_MIN + 4*lfsr.
module f1_start_ctrl #(
    parameter int STEP_TICKS = 500,
    parameter int DELAY_MIN  = 200,
    parameter int RT_W       = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tick,
    input  logic            trigger,
    input  logic            btn,
    input  logic [7:0]      lights,
    output logic            en_out,
    output logic [RT_W-1:0] react_time,
    output logic            result_valid,
    output logic            jump_start,
    output logic            seq_err,
    output logic [2:0]      state_o
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEQ  = 3'd1,
        HOLD = 3'd2,
        GO   = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam int STEP_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
`ifdef F1_START_FIXED_DELAY_EN
    localparam int HOLD_MAX = DELAY_MIN;
`else
    localparam int HOLD_MAX = DELAY_MIN + 4 * 127;
`endif
    localparam int HOLD_W = $clog2(HOLD_MAX + 1);

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [RT_W-1:0]   REACT_MAX = '1;
    localparam logic [3:0]        LAST_LIGHT_PULSE = 4'd7;
    localparam logic [1:0]        AGE_SETTLED = 2'd2;

    state_t              r_state;
    logic [STEP_W-1:0]   r_stepCnt;
    logic [3:0]          r_pulseCnt;
    logic [HOLD_W-1:0]   r_holdCnt;
    logic [RT_W-1:0]     r_reactCnt;
    logic [1:0]          r_age;
    logic                r_en;
    logic [RT_W-1:0]     r_reactTime;
    logic                r_valid;
    logic                r_jump;
    logic                r_seqErr;

    logic [HOLD_W-1:0]   w_holdLoad;
    logic                w_lightsBad;

`ifdef F1_START_FIXED_DELAY_EN
    assign w_holdLoad = HOLD_W'(DELAY_MIN);
`else
    logic [6:0] r_lfsr;
    logic       w_lfsrFb;

    assign w_lfsrFb   = r_lfsr[6] ^ r_lfsr[5];
    assign w_holdLoad = HOLD_W'(DELAY_MIN + 4 * int'(r_lfsr));

    // Free-running x^7+x^6+1 LFSR; seeded non-zero so it never locks up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= 7'h01;
        end else begin
            r_lfsr <= {r_lfsr[5:0], w_lfsrFb};
        end
    end
`endif

    // Lights must be all-on while holding and all-off once the race has started.
    always_comb begin
        w_lightsBad = 1'b0;
        if (r_state == HOLD) begin
            w_lightsBad = (lights != 8'hFF);
        end else if (r_state == GO) begin
            w_lightsBad = (lights != 8'h00);
        end
    end

    // Sequencing FSM: en pulse generation, hold timing, reaction timing and the
    // sticky light-pattern check (age counter lets the light FSM catch up).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_stepCnt   <= '0;
            r_pulseCnt  <= '0;
            r_holdCnt   <= '0;
            r_reactCnt  <= '0;
            r_age       <= '0;
            r_en        <= 1'b0;
            r_reactTime <= '0;
            r_valid     <= 1'b0;
            r_jump      <= 1'b0;
            r_seqErr    <= 1'b0;
        end else begin
            r_en <= 1'b0;

            if (r_age != AGE_SETTLED) begin
                r_age <= r_age + 2'd1;
            end

            if (w_lightsBad && (r_age == AGE_SETTLED)) begin
                r_seqErr <= 1'b1;
            end

            case (r_state)
                IDLE, DONE: begin
                    if (trigger) begin
                        r_state    <= SEQ;
                        r_valid    <= 1'b0;
                        r_jump     <= 1'b0;
                        r_stepCnt  <= '0;
                        r_pulseCnt <= '0;
                    end
                end

                SEQ: begin
                    if (btn) begin
                        r_state     <= DONE;
                        r_jump      <= 1'b1;
                        r_valid     <= 1'b1;
                        r_reactTime <= '0;
                    end else if (tick) begin
                        if (r_stepCnt != STEP_LAST) begin
                            r_stepCnt <= r_stepCnt + STEP_W'(1);
                        end else if (!r_en) begin
                            r_en       <= 1'b1;
                            r_stepCnt  <= '0;
                            r_pulseCnt <= r_pulseCnt + 4'd1;
                            if (r_pulseCnt == LAST_LIGHT_PULSE) begin
                                r_state   <= HOLD;
                                r_holdCnt <= w_holdLoad;
                                r_age     <= '0;
                            end
                        end
                    end
                end

                HOLD: begin
                    if (btn) begin
                        r_state     <= DONE;
                        r_jump      <= 1'b1;
                        r_valid     <= 1'b1;
                        r_reactTime <= '0;
                    end else if (tick) begin
                        if (r_holdCnt != HOLD_ONE) begin
                            r_holdCnt <= r_holdCnt - HOLD_W'(1);
                        end else if (!r_en) begin
                            r_en       <= 1'b1;
                            r_reactCnt <= '0;
                            r_state    <= GO;
                            r_age      <= '0;
                        end
                    end
                end

                GO: begin
                    if (btn) begin
                        r_state     <= DONE;
                        r_reactTime <= r_reactCnt;
                        r_valid     <= 1'b1;
                    end else if (tick && (r_reactCnt != REACT_MAX)) begin
                        r_reactCnt <= r_reactCnt + RT_W'(1);
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign en_out       = r_en;
    assign react_time   = r_reactTime;
    assign result_valid = r_valid;
    assign jump_start   = r_jump;
    assign seq_err      = r_seqErr;
    assign state_o      = r_state;

endmodule

// File: tb/tb_f1_start_ctrl.sv
// tb_f1_start_ctrl: directed bench for f1_start_ctrl with a small F1 light
// FSM model closing the loop from en_out back to lights.
module tb_f1_start_ctrl;

    localparam int STEP_TICKS = 2;
    localparam int DELAY_MIN  = 3;
    localparam int RT_W       = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            tick;
    logic            trigger;
    logic            btn;
    logic [7:0]      lights;
    logic            en_out;
    logic [RT_W-1:0] react_time;
    logic            result_valid;
    logic            jump_start;
    logic            seq_err;
    logic [2:0]      state_o;

    logic [7:0]      modelLights;
    logic            forceEn;
    logic [7:0]      forceVal;

    int              testsRun;
    int              testsFailed;

    int              pulseAt [9];
    logic [7:0]      lightsAt [9];
    int              nPulses;
    bit              consecutive;
    logic [2:0]      startState;
    logic            startValid;
    logic            startJump;

    f1_start_ctrl #(
        .STEP_TICKS(STEP_TICKS),
        .DELAY_MIN (DELAY_MIN),
        .RT_W      (RT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .trigger     (trigger),
        .btn         (btn),
        .lights      (lights),
        .en_out      (en_out),
        .react_time  (react_time),
        .result_valid(result_valid),
        .jump_start  (jump_start),
        .seq_err     (seq_err),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    // Light FSM model: each en lights one more lamp; en on all-on puts them out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            modelLights <= 8'h00;
        end else if (en_out) begin
            modelLights <= (modelLights == 8'hFF) ? 8'h00 : {modelLights[6:0], 1'b1};
        end
    end

    assign lights = forceEn ? forceVal : modelLights;

    // Hard stop so a stuck run can never hang the simulator.
    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic trig, input logic button);
        trigger = trig;
        btn     = button;
        nextCycle();
        trigger = 1'b0;
        btn     = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        nextCycle();
        nextCycle();
        rst = 1'b0;
        nextCycle();
    endtask

    // Trigger a run and record the cycle offset of every en pulse until the ninth.
    task automatic runSequence(input logic withBtn, input int retrigAt, input int budget);
        logic prevEn;
        nPulses     = 0;
        consecutive = 0;
        prevEn      = 1'b0;
        for (int i = 0; i < 9; i++) begin
            pulseAt[i]  = -1;
            lightsAt[i] = 8'hXX;
        end
        applyStimulus(1'b1, withBtn);
        startState = state_o;
        startValid = result_valid;
        startJump  = jump_start;
        for (int off = 1; off <= budget && nPulses < 9; off++) begin
            if (off == retrigAt) trigger = 1'b1;
            nextCycle();
            trigger = 1'b0;
            if (prevEn && en_out) consecutive = 1;
            if (prevEn && nPulses > 0) lightsAt[nPulses-1] = lights;
            if (en_out) begin
                pulseAt[nPulses] = off;
                nPulses++;
            end
            prevEn = en_out;
        end
    endtask

    task automatic test_reset();
        int bad;
        bad = 0;
        rst = 1'b1;
        nextCycle();
        nextCycle();
        testsRun++;
        if (state_o !== 3'd0 || en_out !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_during: state=%0d en=%0b expected 0/0", state_o, en_out);
        end
        rst = 1'b0;
        for (int c = 0; c < 100; c++) begin
            nextCycle();
            testsRun++;
            if (en_out !== 1'b0 || state_o !== 3'd0 || react_time !== '0 ||
                result_valid !== 1'b0 || jump_start !== 1'b0 || seq_err !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL reset_idle c%0d: en=%0b st=%0d rt=%0d v=%0b j=%0b se=%0b expected all 0",
                         c, en_out, state_o, react_time, result_valid, jump_start, seq_err);
            end
        end
    endtask

    task automatic test_clean_run();
        logic [8:0] e;
        runSequence(1'b0, 0, 700);
        testsRun++;
        if (nPulses !== 9) begin
            testsFailed++;
            $display("[TB] FAIL clean_pulses: got %0d expected 9", nPulses);
        end
        testsRun++;
        if (consecutive !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL clean_back_to_back_en: got 1 expected 0");
        end
        for (int i = 0; i < 8; i++) begin
            testsRun++;
            if (pulseAt[i] !== 2 + 2 * i) begin
                testsFailed++;
                $display("[TB] FAIL clean_pulse%0d_time: got %0d expected %0d", i + 1, pulseAt[i], 2 + 2 * i);
            end
            e = (9'd1 << (i + 1)) - 9'd1;
            testsRun++;
            if (lightsAt[i] !== e[7:0]) begin
                testsFailed++;
                $display("[TB] FAIL clean_lights%0d: got %02h expected %02h", i + 1, lightsAt[i], e[7:0]);
            end
        end
`ifdef F1_START_FIXED_DELAY_EN
        testsRun++;
        if (pulseAt[8] !== 19) begin
            testsFailed++;
            $display("[TB] FAIL clean_lights_out_time: got %0d expected 19", pulseAt[8]);
        end
`else
        testsRun++;
        if (pulseAt[8] - pulseAt[7] < 7 || pulseAt[8] - pulseAt[7] > 511) begin
            testsFailed++;
            $display("[TB] FAIL clean_hold_len: got %0d expected 7..511", pulseAt[8] - pulseAt[7]);
        end
`endif
        for (int c = 0; c < 5; c++) nextCycle();
        applyStimulus(1'b0, 1'b1);
        testsRun++;
        if (react_time !== 4'd5 || result_valid !== 1'b1 || jump_start !== 1'b0 || state_o !== 3'd4) begin
            testsFailed++;
            $display("[TB] FAIL clean_result: rt=%0d v=%0b j=%0b st=%0d expected 5/1/0/4",
                     react_time, result_valid, jump_start, state_o);
        end
        testsRun++;
        if (lights !== 8'h00 || seq_err !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL clean_lights_out: lights=%02h se=%0b expected 00/0", lights, seq_err);
        end
    endtask

    task automatic test_back_to_back();
        runSequence(1'b1, 5, 700);
        testsRun++;
        if (startState !== 3'd1 || startValid !== 1'b0 || startJump !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL b2b_trigger_wins: st=%0d v=%0b j=%0b expected 1/0/0",
                     startState, startValid, startJump);
        end
        testsRun++;
        if (nPulses !== 9 || pulseAt[7] !== 16) begin
            testsFailed++;
            $display("[TB] FAIL b2b_retrigger_ignored: pulses=%0d p8=%0d expected 9/16", nPulses, pulseAt[7]);
        end
        applyStimulus(1'b0, 1'b1);
        testsRun++;
        if (react_time !== 4'd0 || result_valid !== 1'b1 || jump_start !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL b2b_instant_btn: rt=%0d v=%0b j=%0b expected 0/1/0",
                     react_time, result_valid, jump_start);
        end
    endtask

    task automatic test_saturation();
        runSequence(1'b0, 0, 700);
        for (int c = 0; c < 30; c++) nextCycle();
        applyStimulus(1'b0, 1'b1);
        testsRun++;
        if (react_time !== 4'd15 || result_valid !== 1'b1 || jump_start !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL saturate: rt=%0d v=%0b j=%0b expected 15/1/0",
                     react_time, result_valid, jump_start);
        end
    endtask

    task automatic test_seq_err();
        bit reachedGo;
        applyStimulus(1'b1, 1'b0);
        for (int off = 1; off <= 17; off++) nextCycle();
        forceEn  = 1'b1;
        forceVal = 8'h7F;
        nextCycle();
        testsRun++;
        if (seq_err !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL seq_err_early: got %0b expected 0", seq_err);
        end
        nextCycle();
        forceEn = 1'b0;
        testsRun++;
        if (seq_err !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL seq_err_set: got %0b expected 1", seq_err);
        end
        reachedGo = 0;
        for (int c = 0; c < 700 && !reachedGo; c++) begin
            if (state_o === 3'd3) reachedGo = 1;
            else nextCycle();
        end
        testsRun++;
        if (!reachedGo) begin
            testsFailed++;
            $display("[TB] FAIL seq_err_flow: state=%0d expected 3 within budget", state_o);
        end
        applyStimulus(1'b0, 1'b1);
        testsRun++;
        if (seq_err !== 1'b1 || state_o !== 3'd4) begin
            testsFailed++;
            $display("[TB] FAIL seq_err_sticky: se=%0b st=%0d expected 1/4", seq_err, state_o);
        end
    endtask

    task automatic test_rst_in_hold();
        applyStimulus(1'b1, 1'b0);
        for (int off = 1; off <= 17; off++) nextCycle();
        testsRun++;
        if (state_o !== 3'd2) begin
            testsFailed++;
            $display("[TB] FAIL rst_hold_pre: state=%0d expected 2", state_o);
        end
        #2;
        rst = 1'b1;
        #1;
        testsRun++;
        if (state_o !== 3'd0 || en_out !== 1'b0 || result_valid !== 1'b0 || jump_start !== 1'b0 ||
            react_time !== '0 || seq_err !== 1'b0 || lights !== 8'h00) begin
            testsFailed++;
            $display("[TB] FAIL rst_hold_async: st=%0d en=%0b v=%0b j=%0b rt=%0d se=%0b l=%02h expected all 0",
                     state_o, en_out, result_valid, jump_start, react_time, seq_err, lights);
        end
        #1;
        rst = 1'b0;
        nextCycle();
        testsRun++;
        if (state_o !== 3'd0) begin
            testsFailed++;
            $display("[TB] FAIL rst_hold_after: state=%0d expected 0", state_o);
        end
    endtask

    task automatic test_jump_hold();
        int pulses;
        pulses = 0;
        applyStimulus(1'b1, 1'b0);
        for (int off = 1; off <= 18; off++) begin
            nextCycle();
            if (en_out) pulses++;
        end
        applyStimulus(1'b0, 1'b1);
        testsRun++;
        if (en_out !== 1'b0 || jump_start !== 1'b1 || result_valid !== 1'b1 ||
            react_time !== '0 || state_o !== 3'd4) begin
            testsFailed++;
            $display("[TB] FAIL jump_hold: en=%0b j=%0b v=%0b rt=%0d st=%0d expected 0/1/1/0/4",
                     en_out, jump_start, result_valid, react_time, state_o);
        end
        for (int c = 0; c < 10; c++) begin
            nextCycle();
            if (en_out) pulses++;
        end
        testsRun++;
        if (pulses !== 8 || lights !== 8'hFF) begin
            testsFailed++;
            $display("[TB] FAIL jump_hold_pulses: pulses=%0d lights=%02h expected 8/FF", pulses, lights);
        end
    endtask

    task automatic test_jump_seq();
        int pulses;
        int lightsBad;
        pulses    = 0;
        lightsBad = 0;
        doReset();
        applyStimulus(1'b1, 1'b0);
        for (int off = 1; off <= 9; off++) begin
            nextCycle();
            if (en_out) pulses++;
        end
        testsRun++;
        if (pulses !== 4 || lights !== 8'h0F) begin
            testsFailed++;
            $display("[TB] FAIL jump_seq_pre: pulses=%0d lights=%02h expected 4/0F", pulses, lights);
        end
        applyStimulus(1'b0, 1'b1);
        testsRun++;
        if (jump_start !== 1'b1 || result_valid !== 1'b1 || react_time !== '0 || state_o !== 3'd4) begin
            testsFailed++;
            $display("[TB] FAIL jump_seq: j=%0b v=%0b rt=%0d st=%0d expected 1/1/0/4",
                     jump_start, result_valid, react_time, state_o);
        end
        for (int c = 0; c < 30; c++) begin
            if (en_out) pulses++;
            if (lights !== 8'h0F) lightsBad++;
            nextCycle();
        end
        testsRun++;
        if (pulses !== 4 || lightsBad !== 0) begin
            testsFailed++;
            $display("[TB] FAIL jump_seq_after: pulses=%0d bad_lights=%0d expected 4/0", pulses, lightsBad);
        end
    endtask

    task automatic test_hold_lengths();
        int len;
        int firstLen;
        int distinct;
        int runs;
        doReset();
        firstLen = -1;
        distinct = 0;
`ifdef F1_START_FIXED_DELAY_EN
        runs = 3;
`else
        runs = 20;
`endif
        for (int r = 0; r < runs; r++) begin
            runSequence(1'b0, 0, 700);
            len = pulseAt[8] - pulseAt[7];
            testsRun++;
`ifdef F1_START_FIXED_DELAY_EN
            if (nPulses !== 9 || len !== DELAY_MIN) begin
                testsFailed++;
                $display("[TB] FAIL hold_len run%0d: pulses=%0d len=%0d expected 9/%0d", r, nPulses, len, DELAY_MIN);
            end
`else
            if (nPulses !== 9 || len < 7 || len > 511) begin
                testsFailed++;
                $display("[TB] FAIL hold_len run%0d: pulses=%0d len=%0d expected 9 and 7..511", r, nPulses, len);
            end
            if (firstLen < 0) firstLen = len;
            else if (len != firstLen) distinct = 1;
`endif
            applyStimulus(1'b0, 1'b1);
        end
`ifndef F1_START_FIXED_DELAY_EN
        testsRun++;
        if (distinct !== 1) begin
            testsFailed++;
            $display("[TB] FAIL hold_len_distinct: got all %0d expected at least 2 values", firstLen);
        end
`endif
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst         = 1'b1;
        tick        = 1'b1;
        trigger     = 1'b0;
        btn         = 1'b0;
        forceEn     = 1'b0;
        forceVal    = 8'h00;

        test_reset();
        test_clean_run();
        test_back_to_back();
        test_saturation();
        test_seq_err();
        test_rst_in_hold();
        test_jump_hold();
        test_jump_seq();
        test_hold_lengths();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
